// File: rtl/smps_pkg.sv
// Shared definitions for the SMPS power-stage sequencer: state encodings,
// fault-cause codes and counter sizing helpers.
package smps_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SOFT_START = 3'd1,
    PG_WAIT    = 3'd2,
    RUN        = 3'd3,
    HICCUP     = 3'd4,
    LATCHED    = 3'd5
  } state_e;

  localparam logic [2:0] FC_NONE = 3'd0;
  localparam logic [2:0] FC_OCP  = 3'd1;
  localparam logic [2:0] FC_OVP  = 3'd2;
  localparam logic [2:0] FC_UVLO = 3'd3;
  localparam logic [2:0] FC_TMO  = 3'd4;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Consecutive-cycle filter: hit asserts on the cycle din has been high for N
// consecutive enabled samples, so an (N-1)-cycle glitch never reaches the FSM.
module debounce_filter
  import smps_pkg::*;
#(
  parameter int N = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic hit
);

  localparam int W = cnt_w(N);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr)  cnt <= '0;
    else if (en) begin
      if (!din)                cnt <= '0;
      else if (cnt != W'(N))   cnt <= cnt + W'(1);
    end
  end

  // Combinational on the current sample so the fault lands on the Nth edge.
  assign hit = en && din && (cnt >= W'(N - 1));

endmodule

// File: rtl/smps_sequencer.sv
// SMPS power-stage sequencer: soft-start, power-good settle, fault supervision
// and bounded hiccup restart with latch-off.
module smps_sequencer
  import smps_pkg::*;
#(
  parameter int SS_TIMEOUT    = 400,
  parameter int PG_DELAY      = 8,
  parameter int HICCUP_CYCLES = 20,
  parameter int MAX_RETRIES   = 3,
  parameter int OCP_FILTER    = 3
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_uvlo_ok,
  input  logic       i_ocp,
  input  logic       i_ovp,
  input  logic       i_ss_done,
  output logic       o_ss_enable,
  output logic       o_ss_clear,
  output logic       o_pwm_enable,
  output logic       o_power_good,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic [1:0] o_retry_count,
  output logic [2:0] o_state
);

  localparam int         CW   = cnt_w(max3(SS_TIMEOUT, PG_DELAY, HICCUP_CYCLES));
  localparam logic [1:0] RMAX = 2'(MAX_RETRIES);

  state_e        state, state_n;
  logic [CW-1:0] tmr;
  logic [1:0]    retry, retry_n;
  logic [2:0]    fcode, fcode_n, cause;
  logic          active, ocp_hit, ss_tmo, fault;
  logic          d_ss_en, d_ss_clr, d_pwm, d_pg, d_fault;

  assign active = (state == SOFT_START) || (state == PG_WAIT) || (state == RUN);

  debounce_filter #(.N(OCP_FILTER)) u_ocp_filt (
    .clk   (i_clk),
    .reset (reset),
    .en    (active),
    .clr   (!active),
    .din   (i_ocp),
    .hit   (ocp_hit)
  );

  assign ss_tmo = (state == SOFT_START) && !i_ss_done && (tmr == CW'(SS_TIMEOUT - 1));

  always_comb begin
    cause = FC_NONE;
    if      (i_ovp)      cause = FC_OVP;
    else if (ocp_hit)    cause = FC_OCP;
    else if (!i_uvlo_ok) cause = FC_UVLO;
    else if (ss_tmo)     cause = FC_TMO;
  end

  assign fault = active && (cause != FC_NONE);

  always_comb begin
    state_n = state;
    retry_n = retry;
    fcode_n = fcode;
    if (!i_enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (i_uvlo_ok) begin
          state_n = SOFT_START;
          retry_n = 2'd0;
          fcode_n = FC_NONE;
        end
        SOFT_START, PG_WAIT, RUN: begin
          if (fault) begin
            fcode_n = cause;
            if (retry < RMAX) begin
              state_n = HICCUP;
              retry_n = retry + 2'd1;
            end else begin
              state_n = LATCHED;
            end
          end else if (state == SOFT_START && i_ss_done) begin
            state_n = PG_WAIT;
          end else if (state == PG_WAIT && tmr == CW'(PG_DELAY - 1)) begin
            state_n = RUN;
            retry_n = 2'd0;
          end
        end
        HICCUP: if (tmr >= CW'(HICCUP_CYCLES - 1) && i_uvlo_ok) state_n = SOFT_START;
        LATCHED: state_n = LATCHED;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    d_ss_en  = 1'b0;
    d_ss_clr = 1'b0;
    d_pwm    = 1'b0;
    d_pg     = 1'b0;
    d_fault  = 1'b0;
    case (state_n)
      SOFT_START, PG_WAIT: begin d_ss_en = 1'b1; d_pwm = 1'b1; end
      RUN:                 begin d_ss_en = 1'b1; d_pwm = 1'b1; d_pg = 1'b1; end
      HICCUP, LATCHED:     begin d_ss_clr = 1'b1; d_fault = 1'b1; end
      default:             d_ss_clr = 1'b1;
    endcase
  end

  // One shared timer: restarts on every state change, saturates while held.
  always_ff @(posedge i_clk) begin
    if (!reset)                tmr <= '0;
    else if (state_n != state) tmr <= '0;
    else if (tmr != '1)        tmr <= tmr + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state        <= IDLE;
      retry        <= 2'd0;
      fcode        <= FC_NONE;
      o_ss_enable  <= 1'b0;
      o_ss_clear   <= 1'b1;
      o_pwm_enable <= 1'b0;
      o_power_good <= 1'b0;
      o_fault      <= 1'b0;
    end else begin
      state        <= state_n;
      retry        <= retry_n;
      fcode        <= fcode_n;
      o_ss_enable  <= d_ss_en;
      o_ss_clear   <= d_ss_clr;
      o_pwm_enable <= d_pwm;
      o_power_good <= d_pg;
      o_fault      <= d_fault;
    end
  end

  assign o_state       = state;
  assign o_retry_count = retry;
  assign o_fault_code  = fcode;

endmodule

// File: tb/tb_smps_sequencer.sv
// Scoreboard bench for smps_sequencer: each step queues the expected output
// snapshot for the coming edge and compares it once the edge has happened.
module tb_smps_sequencer;
  import smps_pkg::*;

  logic       i_clk = 1'b0;
  logic       reset, i_enable, i_uvlo_ok, i_ocp, i_ovp, i_ss_done;
  logic       o_ss_enable, o_ss_clear, o_pwm_enable, o_power_good, o_fault;
  logic [2:0] o_fault_code, o_state;
  logic [1:0] o_retry_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [12:0] exp;
  } exp_t;

  exp_t sb[$];

  smps_sequencer dut (
    .i_clk         (i_clk),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_uvlo_ok     (i_uvlo_ok),
    .i_ocp         (i_ocp),
    .i_ovp         (i_ovp),
    .i_ss_done     (i_ss_done),
    .o_ss_enable   (o_ss_enable),
    .o_ss_clear    (o_ss_clear),
    .o_pwm_enable  (o_pwm_enable),
    .o_power_good  (o_power_good),
    .o_fault       (o_fault),
    .o_fault_code  (o_fault_code),
    .o_retry_count (o_retry_count),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  // Packed snapshot: {state, retry, code, fault, pg, pwm, ss_clear, ss_enable}
  wire [12:0] obs = {o_state, o_retry_count, o_fault_code,
                     o_fault, o_power_good, o_pwm_enable, o_ss_clear, o_ss_enable};

  function automatic logic [12:0] mk(input logic [2:0] st, input logic [1:0] rc,
                                     input logic [2:0] fc);
    logic [4:0] f;
    case (st)
      3'd1, 3'd2: f = 5'b00101;
      3'd3:       f = 5'b01101;
      3'd4, 3'd5: f = 5'b10010;
      default:    f = 5'b00010;
    endcase
    return {st, rc, fc, f};
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [1:0] rc,
                      input logic [2:0] fc);
    exp_t e;
    sb.push_back('{tag, mk(st, rc, fc)});
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic pg_to_run(input logic [1:0] rc, input logic [2:0] fc);
    i_ss_done = 1'b1;
    step("pg_enter", PG_WAIT, rc, fc);
    i_ss_done = 1'b0;
    for (int k = 1; k < 8; k++) step("pg_hold", PG_WAIT, rc, fc);
    step("run_enter", RUN, 2'd0, fc);
  endtask

  initial begin
    reset = 1'b0; i_enable = 1'b0; i_uvlo_ok = 1'b0;
    i_ocp = 1'b0; i_ovp = 1'b0; i_ss_done = 1'b0;
    @(posedge i_clk); #1;
    step("rst_idle", IDLE, 2'd0, FC_NONE);

    // Nominal start
    reset = 1'b1; i_enable = 1'b1; i_uvlo_ok = 1'b1;
    step("ss_start", SOFT_START, 2'd0, FC_NONE);
    for (int k = 1; k < 150; k++) step("ss_ramp", SOFT_START, 2'd0, FC_NONE);
    pg_to_run(2'd0, FC_NONE);
    step("run_hold", RUN, 2'd0, FC_NONE);

    // 2-cycle OCP glitch is filtered out
    i_ocp = 1'b1;
    step("glitch1", RUN, 2'd0, FC_NONE);
    step("glitch2", RUN, 2'd0, FC_NONE);
    i_ocp = 1'b0;
    step("glitch_end", RUN, 2'd0, FC_NONE);

    // 3-cycle OCP is a fault
    i_ocp = 1'b1;
    step("ocp1", RUN, 2'd0, FC_NONE);
    step("ocp2", RUN, 2'd0, FC_NONE);
    step("ocp_hiccup", HICCUP, 2'd1, FC_OCP);
    i_ocp = 1'b0;
    for (int k = 1; k < 20; k++) step("hic_hold", HICCUP, 2'd1, FC_OCP);
    step("hic_restart", SOFT_START, 2'd1, FC_OCP);
    pg_to_run(2'd1, FC_OCP);

    // OVP and filtered OCP on the same edge: OVP wins
    i_ocp = 1'b1;
    step("sim_ocp1", RUN, 2'd0, FC_OCP);
    step("sim_ocp2", RUN, 2'd0, FC_OCP);
    i_ovp = 1'b1;
    step("sim_ovp", HICCUP, 2'd1, FC_OVP);
    i_ocp = 1'b0; i_ovp = 1'b0;

    // UVLO low across hiccup expiry holds HICCUP
    i_uvlo_ok = 1'b0;
    for (int k = 1; k < 20; k++) step("uv_hic", HICCUP, 2'd1, FC_OVP);
    for (int k = 0; k < 5; k++)  step("uv_hold", HICCUP, 2'd1, FC_OVP);
    i_uvlo_ok = 1'b1;
    step("uv_restart", SOFT_START, 2'd1, FC_OVP);

    // Disable beats a same-cycle fault
    i_ovp = 1'b1; i_enable = 1'b0;
    step("dis_fault", IDLE, 2'd1, FC_OVP);
    i_ovp = 1'b0;
    step("dis_idle", IDLE, 2'd1, FC_OVP);

    // Retry exhaustion via soft-start timeout
    i_enable = 1'b1;
    step("ex_start", SOFT_START, 2'd0, FC_NONE);
    for (int a = 1; a <= 4; a++) begin
      for (int k = 1; k < 400; k++)
        step("ex_ss", SOFT_START, 2'(a - 1), (a == 1) ? FC_NONE : FC_TMO);
      if (a < 4) begin
        step("ex_tmo", HICCUP, 2'(a), FC_TMO);
        for (int k = 1; k < 20; k++) step("ex_hic", HICCUP, 2'(a), FC_TMO);
        step("ex_retry", SOFT_START, 2'(a), FC_TMO);
      end else begin
        step("ex_latch", LATCHED, 2'd3, FC_TMO);
      end
    end
    for (int k = 0; k < 5; k++) step("latch_hold", LATCHED, 2'd3, FC_TMO);
    i_enable = 1'b0;
    step("latch_release", IDLE, 2'd3, FC_TMO);

    // Reset mid-RUN
    i_enable = 1'b1;
    step("rr_start", SOFT_START, 2'd0, FC_NONE);
    pg_to_run(2'd0, FC_NONE);
    reset = 1'b0;
    step("rr_reset", IDLE, 2'd0, FC_NONE);
    reset = 1'b1; i_enable = 1'b0;
    step("rr_after", IDLE, 2'd0, FC_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
